pixel_stream_source: RTL and testbench

- Raster-scan pixel transmitter that feeds the median filter's pixel input (new_pixel, rdy/ready handshake).
- Reads a stored grayscale frame from a synchronous-read image memory with 1-cycle read latency.
- Buffers fetched pixels in a 2-entry skid FIFO and presents them in row-major order, one pixel per accepted handshake.
- Sits between the frame memory and median_filter; also supplies frame/line markers to downstream logic.

---
 rtl/pixel_stream_source_pkg.sv | 30 +++
 rtl/pixel_skid_fifo.sv | 55 +++++
 rtl/pixel_stream_source.sv | 196 +++++++++++++++++++
 tb/tb_pixel_stream_source.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_stream_source_pkg.sv
// Shared types and constants for the raster pixel source and its skid FIFO.
package pixel_stream_source_pkg;

  localparam int unsigned PIX_DATA_WIDTH = 8;

  // Grayscale pixel at the default width
  typedef logic [PIX_DATA_WIDTH-1:0] pixel_t;

  // Frame-sequencer states
  localparam int unsigned ST_W     = 2;
  localparam logic [ST_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [ST_W-1:0] ST_FETCH = 2'd1;
  localparam logic [ST_W-1:0] ST_DRAIN = 2'd2;
  localparam logic [ST_W-1:0] ST_DONE  = 2'd3;

  // Position markers carried alongside each pixel
  typedef struct packed {
    logic sof;
    logic eol;
    logic eof;
  } marker_t;

  localparam int unsigned MARKER_W = $bits(marker_t);

  // Counter width able to index 0..v-1, never narrower than one bit
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/pixel_skid_fifo.sv
// Two-entry FIFO holding fetched pixels with their markers.
module pixel_skid_fifo #(
  parameter int unsigned WIDTH = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [1:0]       count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (count_q == 2'd2);
  assign empty_o = (count_q == 2'd0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // Pointer and occupancy update; a push into a full FIFO is only legal with a pop
  always_comb begin
    push_ok  = push_i && (!full_o || pop_i);
    pop_ok   = pop_i && !empty_o;
    wr_ptr_d = push_ok ? ~wr_ptr_q : wr_ptr_q;
    rd_ptr_d = pop_ok  ? ~rd_ptr_q : rd_ptr_q;
    count_d  = count_q + 2'(push_ok) - 2'(pop_ok);
  end

  // Storage and pointer registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= wdata_i;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/pixel_stream_source.sv
// Raster-scan frame reader: fetches a stored frame from synchronous memory and
// streams it pixel by pixel over a rdy/ready handshake with frame/line markers.
module pixel_stream_source
  import pixel_stream_source_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = PIX_DATA_WIDTH,
  parameter int unsigned IMG_WIDTH  = 640,
  parameter int unsigned IMG_HEIGHT = 480,
  parameter int unsigned ADDR_WIDTH = 19
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  mem_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  ready,
  output logic                  rdy,
  output logic [DATA_WIDTH-1:0] new_pixel,
  output logic                  sof,
  output logic                  eol,
  output logic                  eof,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned NUM_PIX = IMG_WIDTH * IMG_HEIGHT;
  localparam int unsigned COL_W   = clog2_min1(IMG_WIDTH);
  localparam int unsigned ROW_W   = clog2_min1(IMG_HEIGHT);
  localparam int unsigned CNT_W   = clog2_min1(NUM_PIX + 1);
  localparam int unsigned ENTRY_W = DATA_WIDTH + MARKER_W;

  // Sequencer and fetch-side state
  logic [ST_W-1:0]       state_q, state_d;
  logic [COL_W-1:0]      col_q, col_d;
  logic [ROW_W-1:0]      row_q, row_d;
  logic [CNT_W-1:0]      fetch_cnt_q, fetch_cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  marker_t               tag_q, tag_d;
  logic                  rvalid_q;
  logic                  eof_seen_q, eof_seen_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  // FIFO interface
  logic               fifo_push;
  logic               fifo_pop;
  logic [ENTRY_W-1:0] fifo_wdata;
  logic [ENTRY_W-1:0] fifo_rdata;
  logic [1:0]         fifo_count;
  logic               fifo_full;
  logic               fifo_empty;

  // Flow-control helpers
  marker_t    head_mk;
  marker_t    issue_mk;
  logic       issue;
  logic       room;
  logic [2:0] occ;
  logic [1:0] cnt_after;

  pixel_skid_fifo #(
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .wdata_i (fifo_wdata),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Returning read data lands in the FIFO with the markers captured at issue
  assign fifo_push  = rvalid_q;
  assign fifo_wdata = {tag_q, mem_rdata};

  // Output side is driven purely by FIFO registers, so rdy never sees ready
  assign rdy       = ~fifo_empty;
  assign fifo_pop  = rdy & ready;
  assign head_mk   = marker_t'(fifo_rdata[ENTRY_W-1 -: MARKER_W]);
  assign new_pixel = fifo_rdata[DATA_WIDTH-1:0];
  assign sof       = head_mk.sof;
  assign eol       = head_mk.eol;
  assign eof       = head_mk.eof;

  assign mem_en   = issue;
  assign mem_addr = addr_q;
  assign busy     = busy_q;
  assign done     = done_q;

  // Markers for the pixel addressed by the fetch counters
  always_comb begin
    issue_mk     = '0;
    issue_mk.sof = (col_q == '0) && (row_q == '0);
    issue_mk.eol = (col_q == COL_W'(IMG_WIDTH - 1));
    issue_mk.eof = issue_mk.eol && (row_q == ROW_W'(IMG_HEIGHT - 1));
  end

  // A read may issue only if its data is guaranteed a FIFO slot whatever ready does next
  always_comb begin
    occ       = 3'(fifo_count) + 3'(rvalid_q);
    room      = (occ < (3'd2 + 3'(fifo_pop))) && !(fifo_full && !fifo_pop);
    cnt_after = fifo_count + 2'(rvalid_q) - 2'(fifo_pop);
  end

  // Next-state logic: frame sequencing, read issue and fetch counters
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    fetch_cnt_d = fetch_cnt_q;
    addr_d      = addr_q;
    tag_d       = tag_q;
    eof_seen_d  = eof_seen_q | (fifo_pop & head_mk.eof);
    issue       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_FETCH;
          col_d       = '0;
          row_d       = '0;
          fetch_cnt_d = '0;
          addr_d      = '0;
          eof_seen_d  = 1'b0;
        end
      end

      ST_FETCH: begin
        issue = (fetch_cnt_q < CNT_W'(NUM_PIX)) && room;
        if (issue) begin
          tag_d       = issue_mk;
          addr_d      = addr_q + ADDR_WIDTH'(1);
          fetch_cnt_d = fetch_cnt_q + CNT_W'(1);
          if (issue_mk.eol) begin
            col_d = '0;
            row_d = row_q + ROW_W'(1);
          end else begin
            col_d = col_q + COL_W'(1);
          end
          if (fetch_cnt_q == CNT_W'(NUM_PIX - 1)) begin
            state_d = ST_DRAIN;
          end
        end
      end

      ST_DRAIN: begin
        if (eof_seen_d && (cnt_after == 2'd0)) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_FETCH) || (state_d == ST_DRAIN);
    done_d = (state_d == ST_DONE);
  end

  // State and fetch-side registers; reset also discards any read in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      col_q       <= '0;
      row_q       <= '0;
      fetch_cnt_q <= '0;
      addr_q      <= '0;
      tag_q       <= '0;
      rvalid_q    <= 1'b0;
      eof_seen_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      fetch_cnt_q <= fetch_cnt_d;
      addr_q      <= addr_d;
      tag_q       <= tag_d;
      rvalid_q    <= issue;
      eof_seen_q  <= eof_seen_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_pixel_stream_source.sv
// Directed + randomized bench for pixel_stream_source (4x3 frame and 1x1 frame).
module tb_pixel_stream_source;

  localparam int unsigned DW   = 8;
  localparam int unsigned W    = 4;
  localparam int unsigned H    = 3;
  localparam int unsigned AW   = 4;
  localparam int unsigned NPIX = W * H;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          start;
  logic          ready;
  logic          mem_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata;
  logic          rdy;
  logic [DW-1:0] new_pixel;
  logic          sof, eol, eof, busy, done;

  logic          start1;
  logic          ready1;
  logic          mem_en1;
  logic [0:0]    mem_addr1;
  logic [DW-1:0] mem_rdata1;
  logic          rdy1;
  logic [DW-1:0] new_pixel1;
  logic          sof1, eol1, eof1, busy1, done1;

  pixel_stream_source #(
    .DATA_WIDTH (DW), .IMG_WIDTH (W), .IMG_HEIGHT (H), .ADDR_WIDTH (AW)
  ) u_dut (
    .clk (clk), .rst (rst), .start (start),
    .mem_en (mem_en), .mem_addr (mem_addr), .mem_rdata (mem_rdata),
    .ready (ready), .rdy (rdy), .new_pixel (new_pixel),
    .sof (sof), .eol (eol), .eof (eof), .busy (busy), .done (done)
  );

  pixel_stream_source #(
    .DATA_WIDTH (DW), .IMG_WIDTH (1), .IMG_HEIGHT (1), .ADDR_WIDTH (1)
  ) u_dut1 (
    .clk (clk), .rst (rst), .start (start1),
    .mem_en (mem_en1), .mem_addr (mem_addr1), .mem_rdata (mem_rdata1),
    .ready (ready1), .rdy (rdy1), .new_pixel (new_pixel1),
    .sof (sof1), .eol (eol1), .eof (eof1), .busy (busy1), .done (done1)
  );

  // Synchronous-read memories: 4x3 holds word = address, 1x1 holds 8'hA5
  always @(posedge clk) if (mem_en)  mem_rdata  <= 8'(mem_addr);
  always @(posedge clk) if (mem_en1) mem_rdata1 <= (mem_addr1 == 1'b0) ? 8'hA5 : 8'h00;

  typedef struct packed {
    logic [DW-1:0] v;
    logic          s;
    logic          l;
    logic          e;
  } pix_t;

  pix_t exp_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   edge_no  = 0;
  int   start_edge, issued, transferred, done_cnt, done_edge, last_xfer_edge, exp_addr;
  bit   check_timing, stalled;
  pix_t held;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    edge_no++;
    #1;
  endtask

  // Reference frame: row-major pixels with markers derived from the index
  task automatic load_model();
    pix_t p;
    exp_q.delete();
    for (int i = 0; i < int'(NPIX); i++) begin
      p.v = 8'(i);
      p.s = (i == 0);
      p.l = ((i % int'(W)) == int'(W) - 1);
      p.e = (i == int'(NPIX) - 1);
      exp_q.push_back(p);
    end
    issued = 0; transferred = 0; done_cnt = 0; done_edge = 0;
    exp_addr = 0; stalled = 0; last_xfer_edge = 0;
  endtask

  // One clock: observe at negedge (what the coming edge will sample), then advance
  task automatic step();
    pix_t got, want;
    @(negedge clk);
    if (mem_en) begin
      if (check_timing && issued == 0) chk("first_en_edge", 32'(edge_no + 1), 32'(start_edge + 1));
      chk("mem_addr", 32'(mem_addr), 32'(exp_addr));
      exp_addr++;
      issued++;
    end
    got = {new_pixel, sof, eol, eof};
    if (stalled) begin
      chk("rdy_hold", 32'(rdy), 32'd1);
      chk("stall_stable", 32'(got), 32'(held));
    end
    if (rdy && ready) begin
      if (exp_q.size() == 0) begin
        chk("extra_pixel", 32'(transferred + 1), 32'(NPIX));
      end else begin
        want = exp_q.pop_front();
        chk("pixel", 32'(got), 32'(want));
        if (check_timing) chk("xfer_edge", 32'(edge_no + 1), 32'(start_edge + 3 + transferred));
      end
      transferred++;
      last_xfer_edge = edge_no + 1;
      stalled = 0;
    end else if (rdy) begin
      stalled = 1;
      held = got;
    end else begin
      stalled = 0;
    end
    if (done) begin
      done_cnt++;
      done_edge = edge_no + 1;
    end
    chk("outstanding_le2", 32'((issued - transferred) <= 2), 32'd1);
    tick();
  endtask

  task automatic start_frame();
    start = 1'b1;
    ready = 1'b0;
    step();
    start = 1'b0;
    start_edge = edge_no;
    chk("busy_rise", 32'(busy), 32'd1);
  endtask

  // mode 0: ready=1, 1: 1,0,0,1 pattern, 2: pulse every 9, other: random
  task automatic run_frame(input int mode, input int start_again_at, input int budget);
    int c;
    bit fin;
    c = 0;
    fin = 0;
    while (!fin) begin
      case (mode)
        0:       ready = 1'b1;
        1:       ready = ((c % 4) == 0) || ((c % 4) == 3);
        2:       ready = ((c % 9) == 8);
        default: ready = 1'($urandom_range(0, 1));
      endcase
      start = (c == start_again_at);
      step();
      start = 1'b0;
      c++;
      if (done_cnt > 0 && edge_no >= done_edge + 2) fin = 1;
      if (!fin && c >= budget) begin
        chk("frame_timeout", 32'(done_cnt), 32'd1);
        fin = 1;
      end
    end
  endtask

  task automatic frame_checks(input string tag);
    chk({tag, "_xfers"}, 32'(transferred), 32'(NPIX));
    chk({tag, "_model_left"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
    chk({tag, "_busy_after"}, 32'(busy), 32'd0);
    chk({tag, "_rdy_after"}, 32'(rdy), 32'd0);
  endtask

  initial begin
    int n1x, d1;
    rst = 1'b1; start = 1'b0; ready = 1'b0; start1 = 1'b0; ready1 = 1'b0;
    check_timing = 0; stalled = 0;
    tick(); tick();

    chk("rst_rdy", 32'(rdy), 32'd0);
    chk("rst_new_pixel", 32'(new_pixel), 32'd0);
    chk("rst_markers", 32'({sof, eol, eof}), 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rdy1", 32'(rdy1), 32'd0);
    rst = 1'b0;
    tick();

    // Free-running frame with exact latency/throughput timing
    load_model();
    check_timing = 1;
    start_frame();
    run_frame(0, -1, 60);
    check_timing = 0;
    frame_checks("free");
    chk("free_done_edge", 32'(done_edge), 32'(last_xfer_edge + 1));

    // Backpressure 1,0,0,1
    load_model();
    start_frame();
    run_frame(1, -1, 200);
    frame_checks("bp");

    // Filter-style single-cycle ready pulses
    load_model();
    start_frame();
    run_frame(2, -1, 300);
    frame_checks("pulse9");

    // Random ready
    load_model();
    start_frame();
    run_frame(3, -1, 300);
    frame_checks("rand");

    // Reset after pixel 5 transfers, then a clean restart
    load_model();
    start_frame();
    for (int c = 0; c < 40 && transferred < 6; c++) begin
      ready = 1'b1;
      step();
    end
    chk("mid_xfers", 32'(transferred), 32'd6);
    rst = 1'b1;
    #1;
    chk("mid_rdy_drop", 32'(rdy), 32'd0);
    chk("mid_busy_drop", 32'(busy), 32'd0);
    chk("mid_mem_en_drop", 32'(mem_en), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    load_model();
    check_timing = 1;
    start_frame();
    run_frame(0, -1, 60);
    check_timing = 0;
    frame_checks("restart");

    // Second start mid-frame must be ignored
    load_model();
    start_frame();
    run_frame(0, 5, 60);
    frame_checks("restart_ignored");

    // 1x1 frame
    start1 = 1'b1;
    ready1 = 1'b1;
    tick();
    start1 = 1'b0;
    n1x = 0;
    d1 = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (mem_en1) chk("addr_1x1", 32'(mem_addr1), 32'd0);
      if (rdy1 && ready1) begin
        n1x++;
        chk("pix_1x1", 32'({new_pixel1, sof1, eol1, eof1}), 32'({8'hA5, 3'b111}));
      end
      if (done1) d1++;
      tick();
    end
    chk("xfers_1x1", 32'(n1x), 32'd1);
    chk("done_1x1", 32'(d1), 32'd1);
    chk("busy_1x1", 32'(busy1), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
